// File: rtl/rk_spi_master.sv
// rk_spi_master
// Byte-wide SPI master (mode 0, MSB first) for the Radio-86RK CPU bus.
// A single CPU write to the data register shifts out a whole byte. The
// byte received during that transfer can then be read back.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   addr      register select: 0 data, 1 status, 2 divider, 3 chip select
//   idata     CPU write data
//   odata     CPU read data, combinational from addr
//   we_n      CPU write strobe, active low. One write per falling edge.
//   rd_n      CPU read strobe, active low. The read takes effect on the rising edge.
//   spi_sclk  serial clock
//   spi_mosi  serial data out, idles high
//   spi_miso  serial data in, sampled directly
//   spi_cs_n  chip selects, active low
//   busy      transfer in progress
//   done      one-clk pulse when a transfer completes
//
// Optional feature: define RK_SPI_AUTOREAD_EN so that a read of addr 0
// while idle also starts a transfer that sends 0xFF.

module rk_spi_master #(
  parameter int NUM_CS    = 1,
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [7:0]        idata,
  output logic [7:0]        odata,
  input  logic              we_n,
  input  logic              rd_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t state, state_next;

  logic              we_q, rd_q;
  logic              wr_ev, rd_ev;
  logic              wr_tx, rd_rx;
  logic              idle, start, finish, overrun_set;
  logic              phase_end, last_bit;
  logic [7:0]        tx_load;
  logic [7:0]        rx, shreg;
  logic [DIV_W-1:0]  div, cur_div, hcnt;
  logic [2:0]        bitcnt;
  logic [NUM_CS-1:0] cs;
  logic              overrun, rdy, mosi_q, done_q;

  // Bus events come from edges of the strobes. A write acts on the falling
  // edge. A read acts on the rising edge, so odata stays stable for as long
  // as rd_n is low.
  assign wr_ev = we_q & ~we_n;
  assign rd_ev = ~rd_q & rd_n;
  assign wr_tx = wr_ev && (addr == 2'd0);
  assign rd_rx = rd_ev && (addr == 2'd0);

  assign idle      = (state == IDLE);
  assign phase_end = (hcnt == cur_div);
  assign last_bit  = (bitcnt == 3'd0);
  assign finish    = (state == HIGH) && phase_end && last_bit;

  // A data write while busy is dropped and only flagged.
  assign overrun_set = wr_tx && !idle;

`ifdef RK_SPI_AUTOREAD_EN
  // A read of the data register while idle starts a dummy 0xFF transfer.
  // If a real write arrives in the same clk, the real write wins.
  logic auto_start;
  assign auto_start = rd_rx && idle && !wr_tx;
  assign start      = (wr_tx && idle) || auto_start;
  assign tx_load    = wr_tx ? idata : 8'hFF;
`else
  assign start   = wr_tx && idle;
  assign tx_load = idata;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: each SCLK phase lasts cur_div+1 clocks
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOW;
      LOW:     if (phase_end) state_next = HIGH;
      HIGH:    if (phase_end) state_next = last_bit ? IDLE : LOW;
      default: state_next = IDLE;
    endcase
  end

  // Outputs derived from state. MOSI is forced high whenever the bus is idle.
  always_comb begin
    spi_sclk = (state == HIGH);
    spi_mosi = idle ? 1'b1 : mosi_q;
    busy     = !idle;
    done     = done_q;
    spi_cs_n = ~cs;
  end

  // Register read mux
  always_comb begin
    odata = 8'h00;
    case (addr)
      2'd0: odata = rx;
      2'd1: odata = {5'b00000, rdy, overrun, busy};
      2'd2: odata[DIV_W-1:0] = div;
      2'd3: odata[NUM_CS-1:0] = cs;
      default: odata = 8'h00;
    endcase
  end

  // Registers, flags and the shift datapath.
  // MISO is captured at the clk where SCLK rises. The next MOSI bit is
  // presented at the clk where SCLK falls. Because the shift register moves
  // left, bit 7 is always the next bit to send.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b1;
      rd_q    <= 1'b1;
      rx      <= 8'hFF;
      div     <= DIV_W'(RESET_DIV);
      cs      <= '0;
      overrun <= 1'b0;
      rdy     <= 1'b0;
      shreg   <= 8'hFF;
      cur_div <= '0;
      hcnt    <= '0;
      bitcnt  <= 3'd0;
      mosi_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      we_q   <= we_n;
      rd_q   <= rd_n;
      done_q <= finish;

      if (wr_ev && (addr == 2'd1)) cs  <= idata[NUM_CS-1:0];
      if (wr_ev && (addr == 2'd2)) div <= idata[DIV_W-1:0];

      // Setting a flag takes priority over clearing it by a read.
      if (overrun_set)                     overrun <= 1'b1;
      else if (rd_ev && (addr == 2'd1))    overrun <= 1'b0;

      if (finish)                          rdy <= 1'b1;
      else if (start || rd_rx)             rdy <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= tx_load;
            cur_div <= div;
            bitcnt  <= 3'd7;
            hcnt    <= '0;
            mosi_q  <= tx_load[7];
          end
        end
        LOW: begin
          if (phase_end) begin
            hcnt  <= '0;
            shreg <= {shreg[6:0], spi_miso};
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            hcnt <= '0;
            if (!last_bit) begin
              bitcnt <= bitcnt - 3'd1;
              mosi_q <= shreg[7];
            end else begin
              rx     <= shreg;
              mosi_q <= 1'b1;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: hcnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rk_spi_master.sv
// tb_rk_spi_master
// Self-checking bench for rk_spi_master, built with NUM_CS=2. A register
// access table covers reset values and the register map. Hand-written
// sequences cover the timed transfers, overrun, reset during a transfer and
// the optional autoread feature. A simple SPI slave model supplies MISO and
// captures MOSI.

module tb_rk_spi_master;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] addr;
  logic [7:0] idata;
  logic [7:0] odata;
  logic       we_n, rd_n;
  logic       spi_sclk, spi_mosi, spi_miso;
  logic [1:0] spi_cs_n;
  logic       busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  rk_spi_master #(.NUM_CS(2), .DIV_W(8), .RESET_DIV(63)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .idata    (idata),
    .odata    (odata),
    .we_n     (we_n),
    .rd_n     (rd_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Slave model: presents slave_byte MSB first, advancing one bit per SCLK rise.
  logic [7:0] slave_byte = 8'hFF;
  int         rise_cnt   = 0;
  int         rise_base  = 0;
  logic [7:0] mosi_cap   = 8'h00;
  logic [2:0] slv_idx;

  assign slv_idx  = 3'd7 - 3'(rise_cnt - rise_base);
  assign spi_miso = slave_byte[slv_idx];

  always @(posedge spi_sclk) begin
    rise_cnt <= rise_cnt + 1;
    mosi_cap <= {mosi_cap[6:0], spi_mosi};
  end

  // Count done pulses and SCLK-high clocks, sampling on the falling clk edge.
  int done_cnt = 0;
  int high_cnt = 0;
  always @(negedge clk) begin
    if (done)     done_cnt <= done_cnt + 1;
    if (spi_sclk) high_cnt <= high_cnt + 1;
  end

  typedef struct {
    bit         wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic [1:0] exp_cs_n;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; idata = d; we_n = 1'b0;
    @(negedge clk);
    we_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; rd_n = 1'b0;
    @(negedge clk);
    d = odata;
    rd_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, output logic [7:0] rd);
    rd = 8'h00;
    if (v.wr) cpu_write(v.addr, v.data);
    else      cpu_read(v.addr, rd);
  endtask

  task automatic arm_slave(input logic [7:0] b);
    slave_byte = b;
    rise_base  = rise_cnt;
  endtask

  // Drive a data write held for 'hold' clocks and return the number of
  // clocks from the we_n fall until busy is seen low (0 = timeout).
  task automatic xfer_timed(input logic [7:0] tx, input int hold, output int lat);
    int  k;
    bit  found;
    k = 0; found = 0; lat = 0;
    @(negedge clk);
    addr = 2'd0; idata = tx; we_n = 1'b0;
    while (k < 400 && !(found && k >= hold)) begin
      @(negedge clk);
      k++;
      if (k == hold) we_n = 1'b1;
      if (!found && !busy) begin
        found = 1;
        lat   = k;
      end
    end
    we_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    checkOutput("wait_idle", busy, 0);
  endtask

  vec_t       vecs[13];
  logic [7:0] rd;
  int         lat, rb, db, hb;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{0, 2'd0, 8'h00, 8'hFF, 2'b11};
    vecs[1]  = '{0, 2'd1, 8'h00, 8'h00, 2'b11};
    vecs[2]  = '{0, 2'd2, 8'h00, 8'h3F, 2'b11};
    vecs[3]  = '{0, 2'd3, 8'h00, 8'h00, 2'b11};
    vecs[4]  = '{1, 2'd1, 8'h02, 8'h00, 2'b01};
    vecs[5]  = '{0, 2'd3, 8'h00, 8'h02, 2'b01};
    vecs[6]  = '{1, 2'd1, 8'h00, 8'h00, 2'b11};
    vecs[7]  = '{1, 2'd3, 8'hFF, 8'h00, 2'b11};
    vecs[8]  = '{0, 2'd3, 8'h00, 8'h00, 2'b11};
    vecs[9]  = '{1, 2'd2, 8'h05, 8'h00, 2'b11};
    vecs[10] = '{0, 2'd2, 8'h00, 8'h05, 2'b11};
    vecs[11] = '{1, 2'd2, 8'h00, 8'h00, 2'b11};
    vecs[12] = '{0, 2'd2, 8'h00, 8'h00, 2'b11};

    reset = 1'b1; addr = 2'd0; idata = 8'h00; we_n = 1'b1; rd_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_sclk", spi_sclk, 0);
    checkOutput("rst_mosi", spi_mosi, 1);
    checkOutput("rst_cs_n", spi_cs_n, 2'b11);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);

    // Register map table
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], rd);
      if (!vecs[i].wr) checkOutput($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      checkOutput($sformatf("vec%0d_cs_n", i), spi_cs_n, vecs[i].exp_cs_n);
    end

    // div=0, 0xA5 out, 0x3C in, we_n held 20 clocks
    arm_slave(8'h3C); db = done_cnt; hb = high_cnt;
    xfer_timed(8'hA5, 20, lat);
    checkOutput("a5_latency", lat, 17);
    checkOutput("a5_rises", rise_cnt - rise_base, 8);
    checkOutput("a5_mosi", mosi_cap, 8'hA5);
    checkOutput("a5_done", done_cnt - db, 1);
    checkOutput("a5_high", high_cnt - hb, 8);
    cpu_read(2'd1, rd); checkOutput("a5_status", rd, 8'h04);
    cpu_read(2'd0, rd); checkOutput("a5_rx", rd, 8'h3C);
    cpu_read(2'd1, rd); checkOutput("a5_status_clr", rd, 8'h00);

    // div=3, 0x00 out, 0xC3 in
    cpu_write(2'd2, 8'h03);
    arm_slave(8'hC3); hb = high_cnt;
    xfer_timed(8'h00, 2, lat);
    checkOutput("d3_latency", lat, 65);
    checkOutput("d3_high", high_cnt - hb, 32);
    checkOutput("d3_mosi", mosi_cap, 8'h00);
    cpu_read(2'd0, rd); checkOutput("d3_rx", rd, 8'hC3);

    // Write while busy is ignored and flags overrun
    arm_slave(8'h5A);
    cpu_write(2'd0, 8'h81);
    cpu_write(2'd0, 8'h00);
    cpu_read(2'd1, rd); checkOutput("ovr_status", rd, 8'h03);
    cpu_read(2'd1, rd); checkOutput("ovr_cleared", rd, 8'h01);
    wait_idle();
    repeat (10) @(negedge clk);
    checkOutput("ovr_rises", rise_cnt - rise_base, 8);
    checkOutput("ovr_mosi", mosi_cap, 8'h81);
    checkOutput("ovr_busy", busy, 0);
    cpu_read(2'd0, rd); checkOutput("ovr_rx", rd, 8'h5A);

    // Reset in the middle of a transfer
    cpu_write(2'd1, 8'h02);
    checkOutput("cs_sel", spi_cs_n, 2'b01);
    db = done_cnt;
    cpu_write(2'd0, 8'hFF);
    repeat (10) @(negedge clk);
    checkOutput("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_sclk", spi_sclk, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_mosi", spi_mosi, 1);
    checkOutput("abort_cs_n", spi_cs_n, 2'b11);
    repeat (80) @(negedge clk);
    checkOutput("abort_done", done_cnt - db, 0);
    cpu_read(2'd2, rd); checkOutput("abort_div", rd, 8'h3F);
    cpu_read(2'd0, rd); checkOutput("abort_rx", rd, 8'hFF);

    // Autoread: load rx=0x12, then read addr 0
    cpu_write(2'd2, 8'h00);
    arm_slave(8'h12);
    cpu_write(2'd0, 8'h00);
    wait_idle();
    arm_slave(8'h34);
    cpu_read(2'd0, rd);
    checkOutput("ar_rd", rd, 8'h12);
`ifdef RK_SPI_AUTOREAD_EN
    checkOutput("ar_busy", busy, 1);
    wait_idle();
    checkOutput("ar_rises", rise_cnt - rise_base, 8);
    checkOutput("ar_mosi", mosi_cap, 8'hFF);
    cpu_read(2'd0, rd); checkOutput("ar_rx", rd, 8'h34);
`else
    repeat (40) @(negedge clk);
    checkOutput("ar_rises", rise_cnt - rise_base, 0);
    checkOutput("ar_busy", busy, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rk_spi_master.md
Name: rk_spi_master

Overview:
- Byte-wide hardware SPI master for SD card and other serial peripherals on the Radio-86RK CPU bus.
- Successor to the top-level bit-banged SD port, which needs one CPU write per bit. This block shifts a whole byte per CPU write.
- Decoded into the 0xA000 I/O window by the top level.
- Generalised over chip-select count, divider width and reset clock rate.
- SPI mode 0 only (CPOL=0, CPHA=0), MSB first.

Parameters:
- NUM_CS, 1, number of chip-select outputs; legal range 1..8.
- DIV_W, 8, width of the SCLK divider register; legal range 1..8.
- RESET_DIV, 63, divider value after reset; at 50 MHz this gives a 390.6 kHz SCLK for SD init.

Ports:
- clk  in  1  system clock (clk50mhz)
- reset  in  1  synchronous, active-high reset
- addr  in  2  register select (CPU addrbus[1:0])
- idata  in  8  CPU write data
- odata  out  8  CPU read data; combinational from addr
- we_n  in  1  CPU write strobe, active low, may be held for many clk cycles
- rd_n  in  1  CPU read strobe, active low, may be held for many clk cycles
- spi_sclk  out  1  serial clock
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in
- spi_cs_n  out  NUM_CS  chip selects, active low
- busy  out  1  transfer in progress
- done  out  1  one-clk pulse when a transfer completes

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Values after reset:
  - spi_sclk=0, spi_mosi=1, spi_cs_n=all 1.
  - busy=0, done=0.
  - rx=0xFF, div=RESET_DIV, cs=0, overrun=0, rdy=0.
- Register write event: we_n 1->0 edge, detected against a registered copy of we_n. Exactly one write event per CPU write, however long we_n is held.
- Register read event:
  - Occurs on the rd_n 0->1 edge.
  - odata is valid for as long as rd_n is low.
  - Side effects of a read happen only at the read event.
- Register map (reads / writes):
  - addr 0, read: rx, the last received byte.
  - addr 0, write: tx byte. Starts a transfer if idle. If busy, the write is ignored and overrun is set.
  - addr 0 read event: clears rdy.
  - addr 1, read: {5'b0, rdy, overrun, busy}.
  - addr 1, write: cs = idata[NUM_CS-1:0]. spi_cs_n = ~cs from the next clk, even mid-transfer.
  - addr 1 read event: clears overrun.
  - addr 2, read/write: div, zero-extended to 8 bits on read. A write while busy is stored and takes effect at the next transfer start.
  - addr 3, read: cs, zero-extended. Writes are ignored.
- State machine: IDLE -> LOW -> HIGH -> LOW ... -> IDLE.
  - IDLE: spi_sclk=0, spi_mosi=1.
  - Start (write event to addr 0 in IDLE):
    - Load shift register with tx and latch div into cur_div.
    - bitcnt=7, hcnt=0.
    - busy=1 and spi_mosi=tx[7] on the next clk. rdy is cleared.
  - Half period = cur_div+1 clk cycles, counted by hcnt.
  - LOW -> HIGH: spi_sclk rises; spi_miso is sampled into the shift register LSB in that same clk.
  - HIGH -> LOW: spi_sclk falls, then:
    - If bitcnt != 0: bitcnt decrements and spi_mosi presents the next bit.
    - If bitcnt == 0: go to IDLE.
- End of transfer (entering IDLE):
  - rx = shift register; busy=0; rdy=1.
  - done pulses high for 1 clk; spi_mosi=1.
- Latency: start edge to busy fall = 1 + 16*(cur_div+1) clk cycles. div=0 gives the maximum SCLK of clk/2.
- Simultaneous events:
  - An rdy-clearing read event in the same clk as the end of transfer: the set wins.
  - An overrun set and an overrun-clear read event in the same clk: the set wins.
- Reset mid-transfer: aborts immediately to the reset values. No done pulse.
- spi_miso is sampled directly. The top level supplies any synchronizer needed.

Optional Feature:
- Macro: RK_SPI_AUTOREAD_EN
- Defined:
  - A read event on addr 0 while idle also starts a transfer with tx=0xFF.
  - The byte returned to the CPU is the rx value shown during the read.
  - Lets the BIOS stream SD blocks with a single LDA per byte.
  - A read event on addr 0 while busy does not set overrun.
- Not defined: reads never start transfers. No autoread logic is synthesised.

Test Plan:
- Reset, then read all registers -> addr0=0xFF, addr1=0x00, addr2=0x3F, addr3=0x00. Outputs: spi_cs_n=1, spi_sclk=0, spi_mosi=1.
- div=0, write 0xA5 to addr 0, slave returns 0x3C, we_n held low 20 clk:
  - Exactly one transfer of 8 SCLK rises.
  - MOSI bits 1,0,1,0,0,1,0,1.
  - busy falls 17 clk after the edge, done pulses once.
  - addr0 reads 0x3C, addr1 reads 0x04.
- div=3: write 0x00 -> each SCLK phase lasts 4 clk; transfer lasts 65 clk.
- Write to addr 0 while busy -> the byte is not sent and the transfer continues unchanged. addr1 reads 0x03; after the read event it reads 0x01 while busy.
- NUM_CS=2: write addr1=0x02 -> spi_cs_n=2'b01; write 0x00 -> spi_cs_n=2'b11. Reset mid-transfer -> sclk=0 next clk, busy=0, no done pulse.
- With RK_SPI_AUTOREAD_EN: with rx=0x12, read addr 0 -> CPU gets 0x12 and a 0xFF transfer starts on the rd_n rise. Without the macro: no SCLK activity.
